// File: rtl/tank_level_conditioner_pkg.sv
// Shared level codes, bargraph patterns and switch-pattern helpers
// for the tank level front end.
package tank_level_conditioner_pkg;

    typedef enum logic [1:0] {
        LVL_EMPTY = 2'd0,
        LVL_LOW   = 2'd1,
        LVL_MID   = 2'd2,
        LVL_HIGH  = 2'd3
    } level_e;

    localparam logic [7:0] BAR_EMPTY = 8'h00;
    localparam logic [7:0] BAR_LOW   = 8'h07;
    localparam logic [7:0] BAR_MID   = 8'h3F;
    localparam logic [7:0] BAR_HIGH  = 8'hFF;
    localparam logic [7:0] BAR_FAULT = 8'hAA;

    // Switches stack bottom-up, so only "filled from the bottom" patterns are real.
    function automatic logic pattern_ok(input logic [2:0] lmh);
        return (lmh == 3'b000) || (lmh == 3'b100) ||
               (lmh == 3'b110) || (lmh == 3'b111);
    endfunction

    function automatic level_e pattern_level(input logic [2:0] lmh);
        level_e lvl;
        unique case (lmh)
            3'b100:  lvl = LVL_LOW;
            3'b110:  lvl = LVL_MID;
            3'b111:  lvl = LVL_HIGH;
            default: lvl = LVL_EMPTY;
        endcase
        return lvl;
    endfunction

    function automatic logic [7:0] bargraph(input level_e lvl);
        logic [7:0] bar;
        unique case (lvl)
            LVL_LOW:  bar = BAR_LOW;
            LVL_MID:  bar = BAR_MID;
            LVL_HIGH: bar = BAR_HIGH;
            default:  bar = BAR_EMPTY;
        endcase
        return bar;
    endfunction

endpackage

// File: rtl/float_switch_debouncer.sv
// One float switch: synchroniser chain, stability debounce and a
// primed flag marking the first completed debounce window.
module float_switch_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic clean_o,
    output logic primed_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          pcnt_q, pcnt_d;
    logic                   stable_q, stable_d;
    logic                   primed_q, primed_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d    = cnt_q;
        pcnt_d   = pcnt_q;
        stable_d = stable_q;
        primed_d = primed_q;
        if (s != stable_q) begin
            pcnt_d = '0;
            if (cnt_q == CNT_LAST) begin
                stable_d = s;
                cnt_d    = '0;
                primed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
            // A channel that never moves still has to prove it is quiet.
            if (!primed_q) begin
                if (pcnt_q == CNT_LAST) begin
                    primed_d = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            stable_q <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            stable_q <= stable_d;
            primed_q <= primed_d;
        end
    end

    assign clean_o  = stable_q;
    assign primed_o = primed_q;

endmodule

// File: rtl/tank_level_conditioner.sv
// Tank float-switch front end: three debounced switches, plausibility
// check with sticky fault, level code and LED bargraph.
module tank_level_conditioner
    import tank_level_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FAULT_CYCLES    = 5000000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       sw_low_raw,
    input  logic       sw_mid_raw,
    input  logic       sw_high_raw,
    input  logic       clear_fault,
    output logic       Low,
    output logic       Mid,
    output logic       High,
    output logic [1:0] level_code,
    output logic       level_valid,
    output logic       level_changed,
    output logic       sensor_fault,
    output logic [7:0] water_indication
);

    localparam int FW = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(FAULT_CYCLES - 1);

    logic [2:0]    primed;
    logic [2:0]    lmh;
    logic          pat_ok;
    logic          fault_set;
    level_e        code_q, code_d;
    logic          changed_q, changed_d;
    logic          invalid_q, invalid_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fault_q, fault_d;
    logic [7:0]    water_q, water_d;

    float_switch_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_low (
        .clk_i   (CLK100MHZ),
        .rst_ni  (CPU_RESETN),
        .raw_i   (sw_low_raw),
        .clean_o (Low),
        .primed_o(primed[2])
    );

    float_switch_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mid (
        .clk_i   (CLK100MHZ),
        .rst_ni  (CPU_RESETN),
        .raw_i   (sw_mid_raw),
        .clean_o (Mid),
        .primed_o(primed[1])
    );

    float_switch_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_high (
        .clk_i   (CLK100MHZ),
        .rst_ni  (CPU_RESETN),
        .raw_i   (sw_high_raw),
        .clean_o (High),
        .primed_o(primed[0])
    );

    assign lmh         = {Low, Mid, High};
    assign pat_ok      = pattern_ok(lmh);
    assign level_valid = &primed;
    assign fault_set   = invalid_q && (fcnt_q == FCNT_LAST);

    always_comb begin
        code_d    = code_q;
        changed_d = 1'b0;
        if (pat_ok && (pattern_level(lmh) != code_q)) begin
            code_d    = pattern_level(lmh);
            changed_d = 1'b1;
        end

        invalid_d = !pat_ok;
        fcnt_d    = '0;
        if (invalid_q && (fcnt_q != FCNT_LAST)) begin
            fcnt_d = fcnt_q + FW'(1);
        end else if (invalid_q) begin
            fcnt_d = fcnt_q;
        end

        // Set takes priority so a fault can never be lost to a stale clear.
        fault_d = fault_q;
        if (fault_set) begin
            fault_d = 1'b1;
        end else if (clear_fault && pat_ok) begin
            fault_d = 1'b0;
        end

        if (!level_valid) begin
            water_d = BAR_EMPTY;
        end else if (fault_d) begin
            water_d = BAR_FAULT;
        end else begin
            water_d = bargraph(code_d);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            code_q    <= LVL_EMPTY;
            changed_q <= 1'b0;
            invalid_q <= 1'b0;
            fcnt_q    <= '0;
            fault_q   <= 1'b0;
            water_q   <= BAR_EMPTY;
        end else begin
            code_q    <= code_d;
            changed_q <= changed_d;
            invalid_q <= invalid_d;
            fcnt_q    <= fcnt_d;
            fault_q   <= fault_d;
            water_q   <= water_d;
        end
    end

    assign level_code       = code_q;
    assign level_changed    = changed_q;
    assign sensor_fault     = fault_q;
    assign water_indication = water_q;

endmodule
